// File: rtl/ysyx_22040386_mdu_if.sv
// ysyx_22040386_mdu_if
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
//   in_valid/in_ready   : request handshake (ALUctr, is_word, src1, src2 travel with it)
//   out_valid/out_ready : response handshake (result travels with it)
//   busy                : unit is not idle
// The master modport is the EX stage; the slave modport is the MDU.
interface ysyx_22040386_mdu_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  ALUctr;
    logic        is_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output in_valid, ALUctr, is_word, src1, src2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, ALUctr, is_word, src1, src2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22040386_mdu.sv
// ysyx_22040386_mdu
// Bit-serial multiply / restoring divide unit for the RV64 M subset
// (mul, div, divu, rem, remu and their *W forms).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; discards any in-flight operation
//   bus : slave side of ysyx_22040386_mdu_if (request in, result out, busy)
// One iteration per cycle: 64 for full-width ops, 32 for word ops.
// Divide-by-zero and unsupported codes skip the iterations.
module ysyx_22040386_mdu (
    input logic                    clk,
    input logic                    rst,
    ysyx_22040386_mdu_if.slave     bus
);
    localparam logic [5:0] OP_MUL  = 6'b01_1000;
    localparam logic [5:0] OP_DIV  = 6'b01_1001;
    localparam logic [5:0] OP_DIVU = 6'b00_1001;
    localparam logic [5:0] OP_REM  = 6'b01_1100;
    localparam logic [5:0] OP_REMU = 6'b00_1100;

    typedef enum logic [1:0] {IDLE, BUSY, FINISH, DONE} state_t;
    state_t state, state_n;

    logic [6:0]  cnt;
    logic [63:0] result_q;

    // Shared datapath registers:
    //   acc : product accumulator / partial remainder
    //   quo : multiplier / dividend shifting into quotient
    //   opb : multiplicand / divisor magnitude
    logic [63:0] acc, quo, opb;
    logic        op_mul, op_rem, op_word, op_bad, op_zero, neg_q, neg_r;

    function automatic logic [63:0] sext_w(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] neg_if(input logic [63:0] x, input logic n);
        return n ? (~x + 64'd1) : x;
    endfunction

    // Request decode, evaluated against the live bus while idle.
    logic               req_mul, req_div, req_signed, req_rem;
    logic signed [63:0] a_ext, b_ext;
    logic               a_neg, b_neg, b_zero, accept, short_op;
    logic [63:0]        a_mag, b_mag;

    always_comb begin
        req_mul    = 1'b0;
        req_div    = 1'b0;
        req_signed = 1'b0;
        req_rem    = 1'b0;
        case (bus.ALUctr)
            OP_MUL:  req_mul = 1'b1;
            OP_DIV:  begin req_div = 1'b1; req_signed = 1'b1; end
            OP_DIVU: req_div = 1'b1;
            OP_REM:  begin req_div = 1'b1; req_signed = 1'b1; req_rem = 1'b1; end
            OP_REMU: begin req_div = 1'b1; req_rem = 1'b1; end
            default: ;
        endcase
        if (bus.is_word) begin
            a_ext = req_signed ? signed'(sext_w(bus.src1[31:0])) : signed'({32'd0, bus.src1[31:0]});
            b_ext = req_signed ? signed'(sext_w(bus.src2[31:0])) : signed'({32'd0, bus.src2[31:0]});
        end else begin
            a_ext = signed'(bus.src1);
            b_ext = signed'(bus.src2);
        end
        a_neg    = req_signed & a_ext[63];
        b_neg    = req_signed & b_ext[63];
        a_mag    = neg_if(a_ext, a_neg);
        b_mag    = neg_if(b_ext, b_neg);
        b_zero   = (b_ext == 64'sd0);
        accept   = bus.in_valid & bus.in_ready;
        short_op = ~(req_mul | req_div) | (req_div & b_zero);
    end

    // One restoring-division step; the trial result is kept only when it is
    // non-negative, which also guarantees it fits back into 64 bits.
    logic [64:0] div_sh;
    logic [65:0] div_diff;
    logic        div_ok;

    always_comb begin
        div_sh   = {acc, quo[63]};
        div_diff = {1'b0, div_sh} - {2'b00, opb};
        div_ok   = (div_diff[65:64] == 2'b00);
    end

    // Final sign fix-up and word sign-extension applied in FINISH.
    logic [63:0] q_fix, r_fix, res_fix;

    always_comb begin
        q_fix   = op_zero ? quo : neg_if(quo, neg_q);
        r_fix   = op_zero ? acc : neg_if(acc, neg_r);
        res_fix = op_mul ? acc : (op_rem ? r_fix : q_fix);
        if (op_word) res_fix = sext_w(res_fix[31:0]);
        if (op_bad)  res_fix = 64'd0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = short_op ? FINISH : BUSY;
            BUSY:    if (cnt == 7'd1) state_n = FINISH;
            FINISH:  state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Iteration counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 7'd0;
            result_q <= 64'd0;
        end else begin
            if (accept)              cnt <= short_op ? 7'd0 : (bus.is_word ? 7'd32 : 7'd64);
            else if (state == BUSY)  cnt <= cnt - 7'd1;
            if (state == FINISH)     result_q <= res_fix;
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            op_mul  <= req_mul;
            op_rem  <= req_rem;
            op_word <= bus.is_word;
            op_bad  <= ~(req_mul | req_div);
            op_zero <= req_div & b_zero;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            if (req_mul) begin
                acc <= 64'd0;
                opb <= a_ext;
                quo <= b_ext;
            end else if (b_zero) begin
                // Divide-by-zero: remainder is the dividend, quotient all ones.
                acc <= a_ext;
                opb <= 64'd0;
                quo <= '1;
            end else begin
                acc <= 64'd0;
                opb <= b_mag;
                // Word dividends start at the top so 32 shifts consume them.
                quo <= bus.is_word ? {a_mag[31:0], 32'd0} : a_mag;
            end
        end else if (state == BUSY) begin
            if (op_mul) begin
                if (quo[0]) acc <= acc + opb;
                opb <= opb << 1;
                quo <= quo >> 1;
            end else begin
                acc <= div_ok ? div_diff[63:0] : div_sh[63:0];
                quo <= {quo[62:0], div_ok};
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) & ~rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: doc/ysyx_22040386_mdu.md
# ysyx_22040386_mdu

Iterative multiply/divide unit on the execute stage; the downstream consumer of the 6-bit ALU control code for the M-extension subset. It accepts an operation code plus two 64-bit operands over a valid/ready handshake, runs a bit-serial shift-add multiply or restoring divide, and returns one 64-bit result over a second valid/ready handshake. The EX stage stalls on `in_ready`/`out_valid`; all other ALU codes stay in the single-cycle ALU.

## Interface
- No parameters; datapath fixed at XLEN = 64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request; equals (state == IDLE) & ~rst.
- `ALUctr` input 6: operation code.
  - 6'b01_1000 = mul.
  - 6'b01_1001 = div.
  - 6'b00_1001 = divu.
  - 6'b01_1100 = rem.
  - 6'b00_1100 = remu.
- `is_word` input 1: RV64 *W variant; operates on the low 32 bits.
- `src1` input 64: multiplicand / dividend.
- `src2` input 64: multiplier / divisor.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer takes the result.
- `result` output 64: operation result.
- `busy` output 1: state != IDLE.

## Operation
- States:
  - IDLE: `in_ready` = 1. On `in_valid` & `in_ready`, latch the op and operands.
    - Normal ops go to BUSY.
    - Divide-by-zero and unsupported codes go to FINISH.
  - BUSY: one iteration per cycle with down-counter `cnt`, loaded with N = 64, or 32 if `is_word`. After the iteration with `cnt` == 1, go to FINISH.
  - FINISH: one cycle. Apply sign fix-up and word sign-extension, register `result`, go to DONE.
  - DONE: `out_valid` = 1; `result` held stable. On `out_ready`, go to IDLE.
- Multiply:
  - Unsigned shift-add on raw operands: `acc` += `mcand` if `mplier[0]`, then `mcand` <<= 1 and `mplier` >>= 1.
  - Keep only the low 64 bits. Signed and unsigned give identical low bits.
  - Word mode: low 32 bits of the operands, 32 iterations, result = sext(`acc[31:0]`).
- Divide/remainder:
  - Restoring division on magnitudes.
    - div/rem: take abs() of the sign-extended operands. Word mode sign-extends from bit 31.
    - divu/remu: zero-extend; no abs().
  - Each iteration: shift the {rem, quo} pair left 1. Trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB.
  - Fix-up in FINISH:
    - Quotient is negated if the operand signs differ (signed ops only).
    - Remainder takes the dividend's sign.
  - Word results are sign-extended from bit 31, including divu/remu.
- Divide-by-zero (divisor operand == 0, word mode checks low 32 bits only):
  - Quotient = all ones.
  - Remainder = dividend (sign-extended to 64 in word mode).
- Signed overflow (most-negative / −1):
  - Quotient = dividend; remainder = 0.
  - Falls out of the magnitude algorithm; no special path.
- Unsupported `ALUctr`: accepted; `result` = 0 via the FINISH path.
- Reset: state = IDLE, `out_valid` = 0, `result` = 0, `cnt` = 0, `busy` = 0. Applies at any state, including mid-BUSY and DONE. The in-flight operation is discarded with no output.

## Timing
- Accept edge = E0.
- Normal op: BUSY occupies edges E1..EN; FINISH at EN+1. `out_valid` is high starting the cycle after edge E(N+1).
  - 64-bit op: `out_valid` seen 65 edges after accept.
  - Word op: 33 edges after accept.
- Divide-by-zero / unsupported code: FINISH at E1, so `out_valid` is high after edge E1.
- `out_valid` and `result` hold while `out_ready` = 0, for any number of cycles.
- Handshake completes on the edge where `out_valid` & `out_ready`. `in_ready` rises the following cycle.
  - No same-cycle result-out/request-in overlap.
  - Minimum issue interval is N + 3 cycles.
- `in_valid` asserted while `in_ready` = 0 is ignored. Inputs need not stay stable after acceptance.

## Test plan
- mul: `src1` = 7, `src2` = 0xFFFFFFFFFFFFFFFD → `result` = 0xFFFFFFFFFFFFFFEB; `out_valid` 65 edges after accept.
- mulw: `src1` = 0x0000000080000000, `src2` = 2, `is_word` = 1 → `result` = 0. Then 0x7FFFFFFF × 2 → 0xFFFFFFFFFFFFFFFE. Latency 33 edges each.
- Signed and unsigned divide:
  - div −7 / 2 → 0xFFFFFFFFFFFFFFFD.
  - rem −7 % 2 → 0xFFFFFFFFFFFFFFFF.
  - divu 0xFFFFFFFFFFFFFFFF / 2 → 0x7FFFFFFFFFFFFFFF.
  - remu 0xFFFFFFFFFFFFFFFF % 2 → 1.
- Divide-by-zero:
  - div 5 / 0 → 0xFFFFFFFFFFFFFFFF.
  - rem 5 % 0 → 5.
  - divw with `src2` = 0x100000000 counts as zero → all ones.
  - `out_valid` one edge after accept in every case.
- Signed overflow:
  - div 0x8000000000000000 / −1 → 0x8000000000000000.
  - rem → 0.
  - divw 0xFFFFFFFF80000000 / −1 → 0xFFFFFFFF80000000.
- Backpressure and reset:
  - Hold `out_ready` = 0 for 10 cycles after `out_valid` → `result` stable, `in_ready` = 0. Release → `in_ready` = 1 the next cycle.
  - Assert `rst` at BUSY cycle 20 → next cycle IDLE, `out_valid` = 0, `result` = 0. No stale result ever appears.
